// File: rtl/uart_tx_word_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_word_feeder
// Brief    : Word FIFO ahead of a byte UART transmitter. Each word is sent
//            LSB byte first, one byte outstanding at a time. Define
//            UART_TX_FEEDER_CHECKSUM_EN to append a mod-256 sum byte per word.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_word_feeder #(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_Wr_DV,
    input  logic [8*WORD_BYTES-1:0] i_Wr_Word,
    output logic                    o_Full,
    output logic                    o_Empty,
    output logic                    o_Overflow,
    output logic                    o_Busy,
    output logic                    o_Tx_DV,
    output logic [7:0]              o_Tx_Byte,
    input  logic                    i_Tx_Active,
    input  logic                    i_Tx_Done
);

    localparam int c_WORD_W = 8 * WORD_BYTES;
    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_IDX_W  = $clog2(WORD_BYTES + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
`ifdef UART_TX_FEEDER_CHECKSUM_EN
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORD_BYTES);
    localparam logic [c_IDX_W-1:0] c_SUM_IDX  = c_IDX_W'(WORD_BYTES - 1);
`else
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORD_BYTES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_ACT  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_WAIT_CLR  = 3'd5
    } state_t;

    state_t                r_state_q,  w_state_d;
    logic [c_CNT_W-1:0]    r_count_q,  w_count_d;
    logic [c_ADDR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [c_ADDR_W-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic                  r_ovf_q,    w_ovf_d;
    logic [c_WORD_W-1:0]   r_shift_q,  w_shift_d;
    logic [c_IDX_W-1:0]    r_idx_q,    w_idx_d;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
    logic [7:0]            r_sum_q,    w_sum_d;
`endif
    logic [c_WORD_W-1:0]   r_mem_q [FIFO_DEPTH];

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_pop;

    // Write acceptance is judged on the pre-edge count, so a write into a
    // full FIFO is dropped even when the FSM pops in the same cycle.
    always_comb begin
        w_full     = (r_count_q == c_DEPTH_CNT);
        w_empty    = (r_count_q == '0);
        w_wr_acc   = i_Wr_DV && !w_full;
        w_pop      = (r_state_q == S_LOAD);
        w_ovf_d    = i_Wr_DV && w_full;
        w_wr_ptr_d = w_wr_acc ? r_wr_ptr_q + c_ADDR_W'(1) : r_wr_ptr_q;
        w_rd_ptr_d = w_pop    ? r_rd_ptr_q + c_ADDR_W'(1) : r_rd_ptr_q;
        w_count_d  = r_count_q;
        case ({w_wr_acc, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    always_comb begin
        w_state_d = r_state_q;
        w_shift_d = r_shift_q;
        w_idx_d   = r_idx_q;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
        w_sum_d   = r_sum_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                // Holding off while a frame is in flight covers a reset
                // that landed mid-byte.
                if (!w_empty && !i_Tx_Active) begin
                    w_state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                w_shift_d = r_mem_q[r_rd_ptr_q];
                w_idx_d   = '0;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                w_sum_d   = 8'd0;
`endif
                w_state_d = S_SEND;
            end
            S_SEND: begin
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                if (r_idx_q != c_LAST_IDX) begin
                    w_sum_d = r_sum_q + r_shift_q[7:0];
                end
`endif
                w_state_d = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                if (i_Tx_Active) begin
                    w_state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    w_state_d = S_WAIT_CLR;
                end
            end
            S_WAIT_CLR: begin
                if (!i_Tx_Done) begin
                    if (r_idx_q != c_LAST_IDX) begin
                        w_idx_d   = r_idx_q + c_IDX_W'(1);
                        w_shift_d = r_shift_q >> 8;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                        if (r_idx_q == c_SUM_IDX) begin
                            w_shift_d = c_WORD_W'(r_sum_q);
                        end
`endif
                        w_state_d = S_SEND;
                    end else begin
                        w_state_d = S_IDLE;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state_q  <= S_IDLE;
            r_count_q  <= '0;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_ovf_q    <= 1'b0;
            r_shift_q  <= '0;
            r_idx_q    <= '0;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
            r_sum_q    <= 8'd0;
`endif
        end else begin
            r_state_q  <= w_state_d;
            r_count_q  <= w_count_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_ovf_q    <= w_ovf_d;
            r_shift_q  <= w_shift_d;
            r_idx_q    <= w_idx_d;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
            r_sum_q    <= w_sum_d;
`endif
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_wr_acc) begin
            r_mem_q[r_wr_ptr_q] <= i_Wr_Word;
        end
    end

    assign o_Full     = w_full;
    assign o_Empty    = w_empty;
    assign o_Overflow = r_ovf_q;
    assign o_Busy     = (r_state_q != S_IDLE);
    assign o_Tx_DV    = (r_state_q == S_SEND);
    assign o_Tx_Byte  = r_shift_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_word_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_word_feeder
// Brief    : Directed bench for uart_tx_word_feeder against a behavioural
//            transmitter (Active for a fixed time, then Done for 2 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_word_feeder;

    localparam int WORD_BYTES = 4;
    localparam int FIFO_DEPTH = 8;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
    localparam int c_FRAME = WORD_BYTES + 1;
`else
    localparam int c_FRAME = WORD_BYTES;
`endif
    localparam int c_ACT_LEN = 12;
    localparam int c_BUDGET  = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_dv = 1'b0;
    logic [31:0] wr_word = '0;
    logic        full, empty, ovf, busy, tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active, tx_done;

    int checks = 0;
    int errors = 0;

    logic       hold_active = 1'b0;
    logic       r_tx_act    = 1'b0;
    logic       r_tx_done   = 1'b0;
    int         r_act_cnt   = 0;
    int         r_done_cnt  = 0;
    logic       r_prev_dv   = 1'b0;
    int         dv_pulses   = 0;
    int         proto_err   = 0;
    int         ovf_cnt     = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign tx_active = r_tx_act | hold_active;
    assign tx_done   = r_tx_done;

    uart_tx_word_feeder #(
        .WORD_BYTES (WORD_BYTES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Word   (wr_word),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Overflow  (ovf),
        .o_Busy      (busy),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    // Transmitter stand-in; a strobe arriving mid-frame or a strobe wider
    // than one cycle counts as a protocol error.
    always @(posedge clk) begin
        r_prev_dv <= tx_dv;
        if (ovf) ovf_cnt <= ovf_cnt + 1;
        if (tx_dv) begin
            if (r_prev_dv || r_tx_act) proto_err <= proto_err + 1;
            dv_pulses <= dv_pulses + 1;
            rx_q.push_back(tx_byte);
            r_tx_act   <= 1'b1;
            r_act_cnt  <= c_ACT_LEN;
            r_tx_done  <= 1'b0;
        end else if (r_tx_act) begin
            if (r_act_cnt == 1) begin
                r_tx_act   <= 1'b0;
                r_tx_done  <= 1'b1;
                r_done_cnt <= 2;
            end else begin
                r_act_cnt <= r_act_cnt - 1;
            end
        end else if (r_tx_done) begin
            if (r_done_cnt == 1) r_tx_done <= 1'b0;
            else r_done_cnt <= r_done_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] w);
        wr_dv   = 1'b1;
        wr_word = w;
        tick();
        wr_dv   = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] w);
        logic [7:0] sum;
        sum = 8'd0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            exp_q.push_back(w[8*b +: 8]);
            sum = sum + w[8*b +: 8];
        end
`ifdef UART_TX_FEEDER_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    task automatic wait_rx(input int n, output bit ok);
        int t;
        t = 0;
        while (rx_q.size() < n && t < c_BUDGET) begin
            tick();
            t++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_quiet(output bit ok);
        int t;
        t = 0;
        while ((busy || !empty || r_tx_act || r_tx_done) && t < c_BUDGET) begin
            tick();
            t++;
        end
        ok = !(busy || !empty || r_tx_act || r_tx_done);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (tx_dv !== 1'b0)     begin errors++; $display("FAIL reset_tx_dv got %b want 0", tx_dv); end
        checks++; if (tx_byte !== 8'h00)  begin errors++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_overflow got %b want 0", ovf); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        int base, dv0;
        bit ok;
        base = rx_q.size();
        dv0  = dv_pulses;
        exp_q.delete();
        push_exp(32'h44332211);
        write_word(32'h44332211);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL lat_e0_empty got %b want 0", empty); end
        tick();
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL lat_load_busy got %b want 1", busy); end
        checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL lat_load_dv got %b want 0", tx_dv); end
        tick();
        checks++; if (tx_dv !== 1'b1) begin errors++; $display("FAIL lat_send_dv got %b want 1", tx_dv); end
        checks++; if (tx_byte !== 8'h11) begin errors++; $display("FAIL lat_send_byte got %h want 11", tx_byte); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_after_load_empty got %b want 1", empty); end
        tick();
        checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL lat_dv_width got %b want 0", tx_dv); end
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got busy=%b want idle", busy); end
        checks++; if (dv_pulses - dv0 !== c_FRAME) begin errors++; $display("FAIL single_dv_count got %0d want %0d", dv_pulses - dv0, c_FRAME); end
        checks++; if (rx_q.size() !== base + exp_q.size()) begin errors++; $display("FAIL single_len got %0d want %0d", rx_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size()) begin errors++; $display("FAIL single_byte%0d got none want %h", i, exp_q[i]); end
            else if (rx_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, rx_q[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int base, ov0;
        bit ok;
        logic [31:0] w;
        wait_quiet(ok);
        base = rx_q.size();
        ov0  = ovf_cnt;
        exp_q.delete();
        // One word is popped at the third edge, so nine of ten writes fit.
        for (int i = 0; i < 10; i++) begin
            w = 32'hA0B0C0D0 + 32'(i) * 32'h01010101;
            if (i < 9) push_exp(w);
            wr_dv   = 1'b1;
            wr_word = w;
            tick();
            if (i == 7) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL b2b_full_at7 got %b want 0", full); end end
            if (i == 8) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full_at8 got %b want 1", full); end
                checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL b2b_ovf_at8 got %b want 0", ovf); end
            end
            if (i == 9) begin checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf_at9 got %b want 1", ovf); end end
        end
        wr_dv = 1'b0;
        tick();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf_width got %b want 0", ovf); end
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got busy=%b want idle", busy); end
        checks++; if (ovf_cnt - ov0 !== 1) begin errors++; $display("FAIL b2b_ovf_count got %0d want 1", ovf_cnt - ov0); end
        checks++; if (rx_q.size() !== base + exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", rx_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size()) begin errors++; $display("FAIL b2b_byte%0d got none want %h", i, exp_q[i]); end
            else if (rx_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, rx_q[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_full_pop();
        int base;
        bit ok;
        logic [31:0] w;
        wait_quiet(ok);
        base = rx_q.size();
        exp_q.delete();
        hold_active = 1'b1;
        tick();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w = 32'h11110000 + 32'(i) * 32'h00010203;
            push_exp(w);
            write_word(w);
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fp_full got %b want 1", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fp_held_idle got busy=%b want 0", busy); end
        hold_active = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fp_load_busy got %b want 1", busy); end
        write_word(32'hDEADBEEF);
        checks++; if (ovf !== 1'b1)  begin errors++; $display("FAIL fp_ovf got %b want 1", ovf); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fp_full_after_pop got %b want 0", full); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fp_empty_after_pop got %b want 0", empty); end
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fp_timeout got busy=%b want idle", busy); end
        checks++; if (rx_q.size() !== base + exp_q.size()) begin errors++; $display("FAIL fp_len got %0d want %0d", rx_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size()) begin errors++; $display("FAIL fp_byte%0d got none want %h", i, exp_q[i]); end
            else if (rx_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL fp_byte%0d got %h want %h", i, rx_q[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_word();
        int base, dv_rst, t;
        bit ok;
        wait_quiet(ok);
        base = rx_q.size();
        write_word(32'hA1B2C3D4);
        wait_rx(base + 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got %0d bytes want 2", rx_q.size() - base); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte got %h want 00", tx_byte); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rstmid_empty got %b want 1", empty); end
        checks++; if (tx_active !== 1'b1) begin errors++; $display("FAIL rstmid_frame_in_flight got %b want 1", tx_active); end
        dv_rst = dv_pulses;
        base   = rx_q.size();
        exp_q.delete();
        push_exp(32'h5A6B7C8D);
        write_word(32'h5A6B7C8D);
        t = 0;
        while (tx_active && t < c_BUDGET) begin
            tick();
            t++;
        end
        checks++; if (dv_pulses !== dv_rst) begin errors++; $display("FAIL rstmid_dv_while_active got %0d want %0d", dv_pulses, dv_rst); end
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_new_timeout got busy=%b want idle", busy); end
        checks++; if (rx_q.size() !== base + exp_q.size()) begin errors++; $display("FAIL rstmid_len got %0d want %0d", rx_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size()) begin errors++; $display("FAIL rstmid_byte%0d got none want %h", i, exp_q[i]); end
            else if (rx_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h want %h", i, rx_q[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_pointer_wrap();
        int base;
        bit ok;
        logic [31:0] w;
        wait_quiet(ok);
        base = rx_q.size();
        exp_q.delete();
        for (int burst = 0; burst < 4; burst++) begin
            for (int k = 0; k < 5; k++) begin
                w = 32'h03020100 + 32'(burst * 5 + k) * 32'h04040404;
                push_exp(w);
                write_word(w);
            end
            wait_quiet(ok);
            checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout burst %0d got busy=%b want idle", burst, busy); end
        end
        checks++; if (rx_q.size() !== base + exp_q.size()) begin errors++; $display("FAIL wrap_len got %0d want %0d", rx_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size()) begin errors++; $display("FAIL wrap_byte%0d got none want %h", i, exp_q[i]); end
            else if (rx_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", i, rx_q[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_checksum();
        int base;
        bit ok;
        logic [7:0] want[$];
`ifdef UART_TX_FEEDER_CHECKSUM_EN
        want = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h0A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
`else
        want = '{8'h04, 8'h03, 8'h02, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
        wait_quiet(ok);
        base = rx_q.size();
        write_word(32'h01020304);
        write_word(32'hFFFFFFFF);
        wait_quiet(ok);
        checks++; if (!ok) begin errors++; $display("FAIL csum_timeout got busy=%b want idle", busy); end
        checks++; if (rx_q.size() !== base + want.size()) begin errors++; $display("FAIL csum_len got %0d want %0d", rx_q.size() - base, want.size()); end
        for (int i = 0; i < want.size(); i++) begin
            checks++;
            if (base + i >= rx_q.size()) begin errors++; $display("FAIL csum_byte%0d got none want %h", i, want[i]); end
            else if (rx_q[base+i] !== want[i]) begin errors++; $display("FAIL csum_byte%0d got %h want %h", i, rx_q[base+i], want[i]); end
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_err !== 0) begin errors++; $display("FAIL protocol_violations got %0d want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_full_pop();
        test_reset_mid_word();
        test_pointer_wrap();
        test_checksum();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
